// File: rtl/i2s_tx_sequencer.sv
// I2S stereo transmit sequencer: BCLK/LRCLK generation, PISO load/shift strobes,
// one-sample holding buffer with underrun flag. Build option: UNDERRUN_ZERO_EN.

module i2s_tx_sequencer #(
  parameter int WIDTH = 32,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  output logic [WIDTH-1:0] piso_data,
  output logic             piso_load,
  output logic             piso_shift,
  output logic             bclk,
  output logic             lrclk,
  output logic             busy,
  output logic             underrun
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(WIDTH - 1);
  localparam logic [SW-1:0] SLOT_LOAD = SW'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CW-1:0]    r_div_cnt;
  logic [SW-1:0]    r_slot;
  logic             r_bclk;
  logic             r_lrclk;
  logic [WIDTH-1:0] r_piso_data;
  logic             r_load;
  logic             r_shift;
  logic             r_underrun;
  logic             r_full;
  logic [WIDTH-1:0] r_buf_l;
  logic [WIDTH-1:0] r_buf_r;
  logic [WIDTH-1:0] r_act_l;
  logic [WIDTH-1:0] r_act_r;

  logic             w_div_wrap;
  logic             w_fall;
  logic             w_slot_last;
  logic [SW-1:0]    w_slot_nxt;
  logic             w_lr_nxt;
  logic             w_load_edge;
  logic             w_left_load;
  logic             w_stop;
  logic             w_accept;

  // Every strobe decision is taken in the cycle before the bclk register falls,
  // so the strobe and the falling edge become visible together.
  always_comb begin
    w_div_wrap  = (r_div_cnt == DIV_LAST);
    w_fall      = (r_state == S_RUN) && w_div_wrap && r_bclk;
    w_slot_last = (r_slot == SLOT_LAST);
    w_slot_nxt  = w_slot_last ? '0 : r_slot + SW'(1);
    w_lr_nxt    = r_lrclk ^ w_slot_last;
    w_load_edge = w_fall && (w_slot_nxt == SLOT_LOAD);
    w_left_load = w_load_edge && !w_lr_nxt;
    w_stop      = w_left_load && !enable;
    w_accept    = sample_valid && !r_full;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (w_stop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_div_cnt   <= '0;
      r_slot      <= '0;
      r_bclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_piso_data <= '0;
      r_load      <= 1'b0;
      r_shift     <= 1'b0;
      r_underrun  <= 1'b0;
      r_full      <= 1'b0;
      r_buf_l     <= '0;
      r_buf_r     <= '0;
      r_act_l     <= '0;
      r_act_r     <= '0;
    end else begin
      r_load     <= 1'b0;
      r_shift    <= 1'b0;
      r_underrun <= 1'b0;

      if (w_accept) begin
        r_buf_l <= left_in;
        r_buf_r <= right_in;
        r_full  <= 1'b1;
      end

      if (r_state != S_RUN || w_stop) begin
        // Idle timing state; also leaves everything ready for a clean slot 0.
        r_div_cnt <= '0;
        r_slot    <= '0;
        r_bclk    <= 1'b0;
        r_lrclk   <= 1'b0;
      end else begin
        r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + CW'(1);
        if (w_div_wrap) begin
          r_bclk <= ~r_bclk;
        end
        if (w_fall) begin
          r_slot  <= w_slot_nxt;
          r_lrclk <= w_lr_nxt;
          if (w_slot_nxt == SLOT_LOAD) begin
            r_load <= 1'b1;
          end else begin
            r_shift <= 1'b1;
          end
        end
        if (w_load_edge && w_lr_nxt) begin
          r_piso_data <= r_act_r;
        end
        // Left load consumes the buffer; accept cannot coincide because it needs it empty.
        if (w_left_load) begin
          if (r_full) begin
            r_act_l     <= r_buf_l;
            r_act_r     <= r_buf_r;
            r_piso_data <= r_buf_l;
            r_full      <= 1'b0;
          end else begin
            r_underrun <= 1'b1;
`ifdef UNDERRUN_ZERO_EN
            r_act_l     <= '0;
            r_act_r     <= '0;
            r_piso_data <= '0;
`else
            r_piso_data <= r_act_l;
`endif
          end
        end
      end
    end
  end

  assign sample_ready = !r_full;
  assign piso_data    = r_piso_data;
  assign piso_load    = r_load;
  assign piso_shift   = r_shift;
  assign bclk         = r_bclk;
  assign lrclk        = r_lrclk;
  assign busy         = (r_state == S_RUN);
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: PISO model plus deserialiser feeding a scoreboard
// of expected PISO loads and reconstructed I2S words.

module tb_i2s_tx_sequencer;

  localparam int WIDTH = 32;
  localparam int DIV   = 2;
  localparam int PHASE = 2 * DIV * WIDTH;
  localparam int FRAME = 4 * DIV * WIDTH;

`ifdef UNDERRUN_ZERO_EN
  localparam logic [WIDTH-1:0] REP1_L = 32'h0000_0000;
  localparam logic [WIDTH-1:0] REP1_R = 32'h0000_0000;
  localparam logic [WIDTH-1:0] REP2_L = 32'h0000_0000;
`else
  localparam logic [WIDTH-1:0] REP1_L = 32'hF0F0_F0F0;
  localparam logic [WIDTH-1:0] REP1_R = 32'h0000_000F;
  localparam logic [WIDTH-1:0] REP2_L = 32'hA5A5_A5A5;
`endif

  logic             clk;
  logic             rstn;
  logic             enable;
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH-1:0] left_in;
  logic [WIDTH-1:0] right_in;
  logic [WIDTH-1:0] piso_data;
  logic             piso_load;
  logic             piso_shift;
  logic             bclk;
  logic             lrclk;
  logic             busy;
  logic             underrun;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_load_q[$];
  logic [WIDTH-1:0] exp_word_q[$];

  i2s_tx_sequencer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .left_in      (left_in),
    .right_in     (right_in),
    .piso_data    (piso_data),
    .piso_load    (piso_load),
    .piso_shift   (piso_shift),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .busy         (busy),
    .underrun     (underrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- PISO model ----------------
  logic [WIDTH-1:0] piso_sreg = '0;
  always @(posedge clk) begin
    if (piso_load)       piso_sreg <= piso_data;
    else if (piso_shift) piso_sreg <= piso_sreg << 1;
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bclk"},   WIDTH'(bclk), '0);
    check({tag, "_lrclk"},  WIDTH'(lrclk), '0);
    check({tag, "_data"},   piso_data, '0);
    check({tag, "_load"},   WIDTH'(piso_load), '0);
    check({tag, "_shift"},  WIDTH'(piso_shift), '0);
    check({tag, "_busy"},   WIDTH'(busy), '0);
    check({tag, "_undr"},   WIDTH'(underrun), '0);
    check({tag, "_ready"},  WIDTH'(sample_ready), WIDTH'(1));
  endtask

  // ---------------- monitor / scoreboard ----------------
  int               cyc = 0;
  logic             prev_bclk = 1'b0;
  logic             prev_lr = 1'b0;
  int               last_rise = -1;
  int               last_lr_t = -1;
  int               ds_cnt = -1;
  logic             ds_lr = 1'b0;
  logic [WIDTH-1:0] ds_acc = '0;

  always @(negedge clk) begin
    logic [WIDTH-1:0] got;
    cyc++;
    if (piso_load || piso_shift) begin
      check("strobe_excl", WIDTH'(piso_load & piso_shift), '0);
      check("strobe_busy", WIDTH'(busy), WIDTH'(1));
      check("strobe_bclk", WIDTH'(bclk), '0);
    end
    if (piso_load) begin
      if (exp_load_q.size() == 0) begin
        check("load_unexpected", piso_data, 'x);
      end else begin
        check("load_data", piso_data, exp_load_q.pop_front());
      end
    end
    if (underrun) begin
      check("underrun_at_left_load", WIDTH'(piso_load & ~lrclk), WIDTH'(1));
    end

    if (!busy) begin
      ds_cnt    = -1;
      ds_lr     = 1'b0;
      last_rise = -1;
      last_lr_t = -1;
    end else begin
      if (lrclk != prev_lr) begin
        if (last_lr_t >= 0) check("lrclk_period", WIDTH'(cyc - last_lr_t), WIDTH'(PHASE));
        last_lr_t = cyc;
      end
      if (bclk && !prev_bclk) begin
        if (last_rise >= 0) check("bclk_period", WIDTH'(cyc - last_rise), WIDTH'(2 * DIV));
        last_rise = cyc;
        if (lrclk != ds_lr) begin
          if (ds_cnt == WIDTH - 1) begin
            got = {ds_acc[WIDTH-2:0], piso_sreg[WIDTH-1]};
            if (exp_word_q.size() == 0) check("word_unexpected", got, 'x);
            else                        check("sd_word", got, exp_word_q.pop_front());
          end
          ds_cnt = 0;
          ds_lr  = lrclk;
        end else if (ds_cnt < 0) begin
          ds_cnt = 0;
        end else begin
          ds_acc = {ds_acc[WIDTH-2:0], piso_sreg[WIDTH-1]};
          ds_cnt++;
        end
      end
    end
    prev_bclk = bclk;
    prev_lr   = lrclk;
  end

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    bit done = 0;
    sample_valid = 1'b1;
    left_in      = l;
    right_in     = r;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (sample_ready) done = 1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    if (!done) check("send_timeout", '0, WIDTH'(1));
  endtask

  task automatic wait_left_load(input string tag);
    bit got = 0;
    for (int i = 0; i < FRAME + 50 && !got; i++) begin
      @(negedge clk);
      if (piso_load && !lrclk) got = 1;
    end
    if (!got) check({tag, "_timeout"}, '0, WIDTH'(1));
  endtask

  task automatic wait_idle(input string tag);
    bit got = 0;
    for (int i = 0; i < FRAME + 50 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) check({tag, "_timeout"}, '0, WIDTH'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rstn         = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    left_in      = '0;
    right_in     = '0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rstn = 1'b1;

    // idle window
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bclk || lrclk || piso_load || piso_shift || busy || !sample_ready) n++;
    end
    check("idle_activity", WIDTH'(n), '0);

    // four frames: normal, underrun, collision, normal then stop
    exp_load_q.push_back(32'hF0F0_F0F0); exp_load_q.push_back(32'h0000_000F);
    exp_load_q.push_back(REP1_L);        exp_load_q.push_back(REP1_R);
    exp_load_q.push_back(REP1_L);        exp_load_q.push_back(REP1_R);
    exp_load_q.push_back(32'hA5A5_A5A5); exp_load_q.push_back(32'h8000_0001);
    exp_word_q.push_back(32'hF0F0_F0F0); exp_word_q.push_back(32'h0000_000F);
    exp_word_q.push_back(REP1_L);        exp_word_q.push_back(REP1_R);
    exp_word_q.push_back(REP1_L);        exp_word_q.push_back(REP1_R);
    exp_word_q.push_back(32'hA5A5_A5A5); exp_word_q.push_back(32'h8000_0001);

    send_sample(32'hF0F0_F0F0, 32'h0000_000F);
    check("ready_after_accept", WIDTH'(sample_ready), '0);
    enable = 1'b1;
    @(negedge clk);
    check("busy_run", WIDTH'(busy), WIDTH'(1));

    wait_left_load("f1");
    check("f1_underrun", WIDTH'(underrun), '0);
    check("f1_ready", WIDTH'(sample_ready), WIDTH'(1));

    wait_left_load("f2");
    check("f2_underrun", WIDTH'(underrun), WIDTH'(1));
    check("f2_ready", WIDTH'(sample_ready), WIDTH'(1));

    // valid is sampled on the very edge that registers the next left load
    repeat (FRAME - 1) @(negedge clk);
    sample_valid = 1'b1;
    left_in      = 32'hA5A5_A5A5;
    right_in     = 32'h8000_0001;
    @(negedge clk);
    sample_valid = 1'b0;
    check("f3_load", WIDTH'(piso_load & ~lrclk), WIDTH'(1));
    check("f3_underrun", WIDTH'(underrun), WIDTH'(1));
    check("f3_ready", WIDTH'(sample_ready), '0);

    wait_left_load("f4");
    check("f4_underrun", WIDTH'(underrun), '0);
    check("f4_ready", WIDTH'(sample_ready), WIDTH'(1));
    repeat (PHASE + 22) @(negedge clk);
    enable = 1'b0;
    wait_idle("stop");
    check("stop_bclk", WIDTH'(bclk), '0);
    check("stop_lrclk", WIDTH'(lrclk), '0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (piso_load || piso_shift || busy || bclk) n++;
    end
    check("stop_quiet", WIDTH'(n), '0);
    check("words_after_stop", WIDTH'(exp_word_q.size()), '0);

    // reset in the middle of the left phase at slot 10
    exp_load_q.push_back(REP2_L);
    enable = 1'b1;
    wait_left_load("r1");
    check("r1_underrun", WIDTH'(underrun), WIDTH'(1));
    n = 0;
    for (int i = 0; i < 200 && n < 9; i++) begin
      @(negedge clk);
      if (piso_shift) n++;
    end
    check("r1_shift_count", WIDTH'(n), WIDTH'(9));
    rstn   = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rstn = 1'b1;
    @(negedge clk);

    // clean restart
    exp_load_q.push_back(32'h1357_9BDF); exp_load_q.push_back(32'h2468_ACE0);
    exp_word_q.push_back(32'h1357_9BDF); exp_word_q.push_back(32'h2468_ACE0);
    send_sample(32'h1357_9BDF, 32'h2468_ACE0);
    enable = 1'b1;
    wait_left_load("r2");
    check("r2_underrun", WIDTH'(underrun), '0);
    repeat (PHASE + 22) @(negedge clk);
    enable = 1'b0;
    wait_idle("stop2");
    repeat (20) @(negedge clk);
    check("load_q_empty", WIDTH'(exp_load_q.size()), '0);
    check("word_q_empty", WIDTH'(exp_word_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
